// File: rtl/simple_ram_dp.sv
// Simple dual-port synchronous RAM: byte-enabled write port, independent read port with
// 1- or 2-cycle latency, selectable read-during-write result and a post-reset clear sequencer.
module simple_ram_dp #(
  parameter int unsigned wordSize    = 8,
  parameter int unsigned addressSize = 8,
  parameter int unsigned readLatency = 1,
  parameter int unsigned rdwMode     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic                     we,
  input  logic [addressSize-1:0]   wr_addr,
  input  logic [wordSize-1:0]      wr_data,
  input  logic [wordSize/8-1:0]    wr_be,
  input  logic                     re,
  input  logic [addressSize-1:0]   rd_addr,
  output logic [wordSize-1:0]      rd_data,
  output logic                     rd_valid
);

  localparam int unsigned NumBytes = wordSize / 8;
  localparam int unsigned Depth    = 2 ** addressSize;
  localparam logic [addressSize-1:0] LastAddr = '1;

  if ((wordSize % 8) != 0 || wordSize == 0) begin : g_bad_word_size
    $error("simple_ram_dp: wordSize must be a non-zero multiple of 8");
  end
  if (readLatency != 1 && readLatency != 2) begin : g_bad_latency
    $error("simple_ram_dp: readLatency must be 1 or 2");
  end

  typedef enum logic {StClear, StReady} state_e;

  state_e                 r_state;
  logic [addressSize-1:0] r_cnt;
  logic                   r_ready;

  logic [wordSize-1:0]    r_mem [Depth];

  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic                   w_clr_we;
  logic [wordSize-1:0]    w_rd_old;
  logic [wordSize-1:0]    w_rd_word;

  logic [wordSize-1:0]    r_s1_data;
  logic                   r_s1_valid;

  // Port requests are only honoured once the clear has finished and never on a reset edge.
  assign w_wr_acc = r_ready & we & ~rst;
  assign w_rd_acc = r_ready & re & ~rst;
  assign w_clr_we = (r_state == StClear) & ~rst;

  assign ready = r_ready;

  // Clear sequencer: one word per cycle, READY on the edge that zeroes the last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StClear;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        StClear: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LastAddr) begin
            r_state <= StReady;
            r_ready <= 1'b1;
          end
        end
        StReady: begin
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= StClear;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign w_rd_old = r_mem[rd_addr];

  // New-data mode forwards the enabled bytes of a same-address write into the read result.
  always_comb begin
    w_rd_word = w_rd_old;
    if (rdwMode == 1 && w_wr_acc && (wr_addr == rd_addr)) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wr_be[i]) begin
          w_rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  if (readLatency == 2) begin : g_lat2
    logic [wordSize-1:0] r_s2_data;
    logic                r_s2_valid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_s2_valid <= 1'b0;
        r_s2_data  <= '0;
      end else begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= r_s1_data;
        end
      end
    end

    assign rd_data  = r_s2_data;
    assign rd_valid = r_s2_valid;
  end else begin : g_lat1
    assign rd_data  = r_s1_data;
    assign rd_valid = r_s1_valid;
  end

endmodule

// File: tb/tb_simple_ram_dp.sv
// Scoreboard bench: instance A (32-bit, latency 2, old-data RDW) and instance B
// (8-bit, latency 1, new-data RDW), both 16 words deep, sharing clock and reset.
module tb_simple_ram_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        a_ready, a_we, a_re, a_rd_valid;
  logic [3:0]  a_wr_addr, a_rd_addr, a_wr_be;
  logic [31:0] a_wr_data, a_rd_data;

  logic        b_ready, b_we, b_re, b_rd_valid;
  logic [3:0]  b_wr_addr, b_rd_addr;
  logic [0:0]  b_wr_be;
  logic [7:0]  b_wr_data, b_rd_data;

  simple_ram_dp #(
    .wordSize(32), .addressSize(4), .readLatency(2), .rdwMode(0)
  ) u_a (
    .clk(clk), .rst(rst), .ready(a_ready),
    .we(a_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
    .re(a_re), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  simple_ram_dp #(
    .wordSize(8), .addressSize(4), .readLatency(1), .rdwMode(1)
  ) u_b (
    .clk(clk), .rst(rst), .ready(b_ready),
    .we(b_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
    .re(b_re), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, required 0x%h", name, act, req);
    end
  endfunction

  // Monitor: every rd_valid must match the oldest outstanding read, in data and in cycle.
  always @(negedge clk) begin
    if (a_rd_valid === 1'b1) begin
      if (qa.size() == 0) begin
        check("a unexpected rd_valid", 32'd1, 32'd0);
      end else begin
        ea = qa.pop_front();
        check("a rd_data", a_rd_data, ea.data);
        check("a rd_valid cycle", cyc, ea.cyc);
      end
    end
    if (b_rd_valid === 1'b1) begin
      if (qb.size() == 0) begin
        check("b unexpected rd_valid", 32'd1, 32'd0);
      end else begin
        eb = qb.pop_front();
        check("b rd_data", {24'd0, b_rd_data}, eb.data);
        check("b rd_valid cycle", cyc, eb.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    a_we = 1'b0;
    a_re = 1'b0;
    b_we = 1'b0;
    b_re = 1'b0;
  endtask

  task automatic a_wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    a_we = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
  endtask

  task automatic b_wr(input logic [3:0] addr, input logic [7:0] data, input logic be);
    b_we = 1'b1; b_wr_addr = addr; b_wr_data = data; b_wr_be = be;
  endtask

  task automatic a_rd(input logic [3:0] addr, input logic [31:0] exp, input bit chk);
    a_re = 1'b1; a_rd_addr = addr;
    if (chk) qa.push_back('{data: exp, cyc: cyc + 2});
  endtask

  task automatic b_rd(input logic [3:0] addr, input logic [7:0] exp, input bit chk);
    b_re = 1'b1; b_rd_addr = addr;
    if (chk) qb.push_back('{data: {24'd0, exp}, cyc: cyc + 1});
  endtask

  // Called just after the last reset edge; counts sampled cycles with ready low.
  task automatic wait_ready(input bit poke_while_clearing);
    int low_a = 0;
    int low_b = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_ready === 1'b1 && b_ready === 1'b1) break;
      if (a_ready !== 1'b1) low_a++;
      if (b_ready !== 1'b1) low_b++;
      if (poke_while_clearing && k == 3) begin
        a_wr(4'd2, 32'hFFFF_FFFF, 4'hF);
        a_rd(4'd2, 32'd0, 1'b0);
        b_wr(4'd2, 8'hFF, 1'b1);
        b_rd(4'd2, 8'd0, 1'b0);
      end
      tick();
    end
    check("a ready-low cycles", low_a, 32'd16);
    check("b ready-low cycles", low_b, 32'd16);
    check("a ready after clear", {31'd0, a_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running, required finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a_we = 1'b0; a_re = 1'b0; a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0; a_wr_be = '0;
    b_we = 1'b0; b_re = 1'b0; b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0; b_wr_be = '0;
    tick();
    tick();
    rst = 1'b0;

    check("a reset ready", {31'd0, a_ready}, 32'd0);
    check("a reset rd_valid", {31'd0, a_rd_valid}, 32'd0);
    check("a reset rd_data", a_rd_data, 32'd0);
    check("b reset rd_data", {24'd0, b_rd_data}, 32'd0);

    // Clear timing, with requests poked into the clear window.
    wait_ready(1'b1);

    // Every word cleared, including address 2 that was targeted during the clear.
    for (int i = 0; i < 16; i++) begin
      a_rd(4'(i), 32'd0, 1'b1);
      b_rd(4'(i), 8'd0, 1'b1);
      tick();
    end

    // Byte enables.
    a_wr(4'd5, 32'h1122_3344, 4'hF);
    tick();
    a_wr(4'd5, 32'hAABB_CCDD, 4'b0101);
    b_wr(4'd7, 8'h99, 1'b1);
    tick();
    a_rd(4'd5, 32'h11BB_33DD, 1'b1);
    b_wr(4'd7, 8'h55, 1'b0);
    tick();
    b_rd(4'd7, 8'h99, 1'b1);
    tick();

    // Latency: a lone read, then three back-to-back reads.
    a_wr(4'd3, 32'h0000_007E, 4'hF);
    b_wr(4'd3, 8'h7E, 1'b1);
    tick();
    a_wr(4'd4, 32'h1234_5678, 4'hF);
    b_wr(4'd4, 8'hC3, 1'b1);
    tick();
    a_wr(4'd6, 32'hCAFE_F00D, 4'hF);
    b_wr(4'd6, 8'h3C, 1'b1);
    tick();
    a_rd(4'd3, 32'h0000_007E, 1'b1);
    b_rd(4'd3, 8'h7E, 1'b1);
    tick();
    tick();
    tick();
    a_rd(4'd3, 32'h0000_007E, 1'b1);
    b_rd(4'd3, 8'h7E, 1'b1);
    tick();
    a_rd(4'd4, 32'h1234_5678, 1'b1);
    b_rd(4'd4, 8'hC3, 1'b1);
    tick();
    a_rd(4'd6, 32'hCAFE_F00D, 1'b1);
    b_rd(4'd6, 8'h3C, 1'b1);
    tick();

    // Read during write at address 9 (still zero): A returns old, B returns new.
    a_wr(4'd9, 32'h0000_005A, 4'hF);
    a_rd(4'd9, 32'd0, 1'b1);
    b_wr(4'd9, 8'h5A, 1'b1);
    b_rd(4'd9, 8'h5A, 1'b1);
    tick();
    // Different addresses in the same cycle are independent.
    a_wr(4'd10, 32'h0102_0304, 4'hF);
    a_rd(4'd9, 32'h0000_005A, 1'b1);
    b_wr(4'd10, 8'hE1, 1'b1);
    b_rd(4'd9, 8'h5A, 1'b1);
    tick();
    a_rd(4'd10, 32'h0102_0304, 1'b1);
    b_rd(4'd10, 8'hE1, 1'b1);
    tick();
    tick();
    tick();
    tick();

    // Reset while an A read is in flight: the read is dropped and memory re-cleared.
    a_rd(4'd5, 32'd0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("a rd_valid after mid-read reset", {31'd0, a_rd_valid}, 32'd0);
    check("a rd_data after mid-read reset", a_rd_data, 32'd0);
    check("a ready after mid-read reset", {31'd0, a_ready}, 32'd0);
    check("b rd_data after mid-read reset", {24'd0, b_rd_data}, 32'd0);
    wait_ready(1'b0);
    a_rd(4'd5, 32'd0, 1'b1);
    b_rd(4'd7, 8'd0, 1'b1);
    tick();
    a_rd(4'd3, 32'd0, 1'b1);
    b_rd(4'd3, 8'd0, 1'b1);
    tick();
    tick();
    tick();
    tick();

    check("a all reads returned", qa.size(), 32'd0);
    check("b all reads returned", qb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
